// File: rtl/cam_pkg.sv
// cam_pkg: shared state encoding and ROM marker words for the camera configuration sequencer
package cam_pkg;
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        SEND,
        WAIT_BUSY,
        WAIT_READY,
        DELAY,
        DONE
    } state_t;

    localparam logic [15:0] ROM_END   = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY = 16'hFFF0;
endpackage

// File: rtl/cfg_delay_timer.sv
// cfg_delay_timer: loadable down-counter that holds at zero and flags when it gets there
module cfg_delay_timer #(
    parameter int unsigned CYCLES = 270000
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_load,
    input  logic i_count,
    output logic o_zero
);
    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // reload on request, otherwise count down and stop at zero
    always_comb cnt_d = i_load ? LOAD_VAL : (i_count && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

    // counter register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign o_zero = cnt_q == '0;
endmodule

// File: rtl/cam_config.sv
// cam_config: walks a config ROM, issuing one SCCB write per entry with delay and end markers
module cam_config
    import cam_pkg::*;
#(
    parameter int unsigned CLK_F    = 27000000,
    parameter int unsigned DELAY_MS = 10
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    output logic [7:0]  o_rom_addr,
    input  logic [15:0] i_rom_data,
    output logic        o_sccb_start,
    output logic [7:0]  o_sccb_addr,
    output logic [7:0]  o_sccb_data,
    input  logic        i_sccb_ready,
    output logic        o_done
);
    localparam int unsigned CYCLES = CLK_F / 1000 * DELAY_MS;

    state_t      state_q, state_d;
    logic [7:0]  rom_addr_q, rom_addr_d;
    logic [7:0]  sccb_addr_q, sccb_addr_d;
    logic [7:0]  sccb_data_q, sccb_data_d;
    logic        is_end, is_delay, start_ok, advance, last, latch, delay_zero;

    assign is_end   = i_rom_data == ROM_END;
    assign is_delay = i_rom_data == ROM_DELAY;
    assign start_ok = i_start && (state_q == IDLE || state_q == DONE);
    assign advance  = (state_q == WAIT_READY && i_sccb_ready) || (state_q == DELAY && delay_zero);
    assign last     = rom_addr_q == 8'hFF;
    assign latch    = state_q == DECODE && !is_end && !is_delay && i_sccb_ready;

    cfg_delay_timer #(.CYCLES(CYCLES)) u_delay (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_load  (state_q == DECODE && is_delay),
        .i_count (state_q == DELAY),
        .o_zero  (delay_zero)
    );

    // state and datapath registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            sccb_addr_q <= '0;
            sccb_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            sccb_addr_q <= sccb_addr_d;
            sccb_data_q <= sccb_data_d;
        end
    end

    // next state: one ROM entry per pass, waiting out the SCCB busy/ready handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = i_start ? FETCH : state_q;
            FETCH:      state_d = DECODE;
            DECODE:     state_d = is_end ? DONE : is_delay ? DELAY : i_sccb_ready ? SEND : DECODE;
            SEND:       state_d = WAIT_BUSY;
            WAIT_BUSY:  state_d = i_sccb_ready ? WAIT_BUSY : WAIT_READY;
            WAIT_READY,
            DELAY:      state_d = advance ? (last ? DONE : FETCH) : state_q;
            default:    state_d = IDLE;
        endcase
    end

    // next datapath values: address restarts on start and saturates at 255; write payload latched in DECODE
    always_comb begin
        rom_addr_d  = start_ok ? 8'd0 : (advance && !last) ? rom_addr_q + 8'd1 : rom_addr_q;
        sccb_addr_d = latch ? i_rom_data[15:8] : sccb_addr_q;
        sccb_data_d = latch ? i_rom_data[7:0]  : sccb_data_q;
    end

    // outputs decoded from the current state
    always_comb begin
        o_sccb_start = state_q == SEND;
        o_done       = state_q == DONE;
        o_rom_addr   = rom_addr_q;
        o_sccb_addr  = sccb_addr_q;
        o_sccb_data  = sccb_data_q;
    end
endmodule

// File: tb/tb_cam_config.sv
// tb_cam_config: scoreboard bench with registered ROM model and a busy-for-3-cycles SCCB stub
module tb_cam_config;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        ready;
    logic [7:0]  rom_addr, s_addr, s_data;
    logic [15:0] rom_data;
    logic        s_start, done;
    logic [15:0] rom [256];
    logic [15:0] exp_w;
    logic [15:0] exp_q [$];
    int          busy = 0;
    bit          hold_low = 1'b0;
    int          cyc = 0, pulses = 0, last_pulse_cyc = 0;
    int          checks = 0, errors = 0, m_checks = 0, m_errors = 0;
    int          base, t0;

    always #5 clk = ~clk;

    cam_config #(.CLK_F(27000000), .DELAY_MS(1)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .o_rom_addr   (rom_addr),
        .i_rom_data   (rom_data),
        .o_sccb_start (s_start),
        .o_sccb_addr  (s_addr),
        .o_sccb_data  (s_data),
        .i_sccb_ready (ready),
        .o_done       (done)
    );

    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        busy <= s_start ? 3 : (busy > 0 ? busy - 1 : 0);
    end

    assign ready = busy == 0 && !hold_low;

    always @(negedge clk) begin
        if (s_start) begin
            pulses = pulses + 1;
            last_pulse_cyc = cyc;
            m_checks = m_checks + 1;
            if (exp_q.size() == 0) begin
                m_errors = m_errors + 1;
                $display("FAIL unexpected_write: got %h_%h, required no write", s_addr, s_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({s_addr, s_data} !== exp_w) begin
                    m_errors = m_errors + 1;
                    $display("FAIL sccb_write: got %h_%h, required %h_%h", s_addr, s_data, exp_w[15:8], exp_w[7:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic check(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", n, act, exp);
        end
    endtask

    task automatic set_rom3(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = w0;
        rom[1] = w1;
        rom[2] = w2;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string n);
        for (int i = 0; i < bound && !done; i++) @(negedge clk);
        check(n, int'(done), 1);
    endtask

    task automatic check_reset_outputs(input string n);
        check({n, "_rom_addr"}, int'(rom_addr), 0);
        check({n, "_start"}, int'(s_start), 0);
        check({n, "_sccb_addr"}, int'(s_addr), 0);
        check({n, "_sccb_data"}, int'(s_data), 0);
        check({n, "_done"}, int'(done), 0);
    endtask

    initial begin
        set_rom3(16'h1280, 16'h1204, 16'hFFFF);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_done", int'(done), 0);

        // two writes then end marker
        base = pulses;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1204);
        pulse_start();
        wait_done(200, "basic_done");
        check("basic_pulses", pulses - base, 2);
        check("basic_addr", int'(rom_addr), 2);
        check("basic_q_empty", exp_q.size(), 0);

        // delay marker before first write
        set_rom3(16'hFFF0, 16'h1100, 16'hFFFF);
        base = pulses;
        exp_q.push_back(16'h1100);
        pulse_start();
        wait_done(28000, "delay_done");
        check("delay_pulses", pulses - base, 1);
        check("delay_min_latency", int'((last_pulse_cyc - t0) >= 27000), 1);
        check("delay_max_latency", int'((last_pulse_cyc - t0) <= 27010), 1);

        // ready held low at DECODE
        set_rom3(16'h1100, 16'hFFFF, 16'hFFFF);
        hold_low = 1'b1;
        base = pulses;
        exp_q.push_back(16'h1100);
        pulse_start();
        repeat (500) @(negedge clk);
        check("stall_no_pulse", pulses - base, 0);
        hold_low = 1'b0;
        wait_done(100, "stall_done");
        check("stall_pulses", pulses - base, 1);

        // start mid-sequence ignored, then rerun from DONE
        set_rom3(16'h1280, 16'h1204, 16'hFFFF);
        base = pulses;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1204);
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
        wait_done(200, "midstart_done");
        check("midstart_pulses", pulses - base, 2);
        base = pulses;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1204);
        pulse_start();
        check("rerun_done_cleared", int'(done), 0);
        wait_done(200, "rerun_done");
        check("rerun_pulses", pulses - base, 2);
        check("rerun_q_empty", exp_q.size(), 0);

        // reset during WAIT_READY of the second write
        base = pulses;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1204);
        pulse_start();
        for (int i = 0; i < 200 && pulses - base < 2; i++) @(negedge clk);
        check("abort_second_seen", pulses - base, 2);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_idle_pulses", pulses - base, 2);
        check("abort_idle_done", int'(done), 0);
        check("abort_idle_addr", int'(rom_addr), 0);
        base = pulses;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1204);
        pulse_start();
        wait_done(200, "replay_done");
        check("replay_pulses", pulses - base, 2);

        // every entry is a write: 256 writes, address saturates at 255
        for (int i = 0; i < 256; i++) rom[i] = 16'h1100;
        base = pulses;
        for (int i = 0; i < 256; i++) exp_q.push_back(16'h1100);
        pulse_start();
        wait_done(5000, "full_done");
        check("full_pulses", pulses - base, 256);
        check("full_addr", int'(rom_addr), 255);
        repeat (10) @(negedge clk);
        check("full_no_wrap_addr", int'(rom_addr), 255);
        check("full_hold_done", int'(done), 1);
        check("full_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks + m_checks, errors + m_errors);
        $finish;
    end
endmodule
